uart_tx_engine: RTL and testbench

Synthesizable UART serial transmitter for the usb2uart datapath. It accepts one byte per valid/ready handshake and serialises it onto `sout`: start bit, 5–8 data bits LSB-first, optional even/odd parity, then 1, 1.5 or 2 stop bits. Bit timing comes from a 16x oversampling divisor. The block is the DUT-side driver of the line that the bench UART agent samples and checks.

---
 rtl/uart_tx_engine.sv | 117 +++++++++++
 tb/tb_uart_tx_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 16x-oversampled UART serialiser (5-8 data bits, even/odd parity, 1/1.5/2 stop bits); define UART_TX_BREAK_EN to add the break_ctrl line-break input
module uart_tx_engine #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] divisor,
   input  logic [1:0]       data_bits,
   input  logic             stop_bits,
   input  logic             parity_en,
   input  logic             even_parity,
   input  logic             tx_valid,
   input  logic [7:0]       tx_data,
`ifdef UART_TX_BREAK_EN
   input  logic             break_ctrl,
`endif
   output logic             tx_ready,
   output logic             sout,
   output logic             tx_busy,
   output logic             tx_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
   state_t state, state_n;
   logic [DIV_W-1:0] div_q, pre_cnt;
   logic [3:0] tick_cnt;
   logic [2:0] bit_idx, bit_idx_n;
   logic [7:0] data_q;
   logic [1:0] nbits_q;
   logic stop2_q, par_en_q, even_q;
   logic tick, bit_end, accept, line_n, brk;
`ifdef UART_TX_BREAK_EN
   assign brk = break_ctrl;
`else
   assign brk = 1'b0;
`endif
   assign tx_ready = (state == IDLE) && !brk;
   assign tx_busy = state != IDLE;
   assign accept = tx_valid && tx_ready;
   assign tick = pre_cnt == div_q;
   assign bit_end = tick && (tick_cnt == ((state == STOP2 && nbits_q == 2'd0) ? 4'd7 : 4'd15));
   assign tx_done = bit_end && (state == STOP2 || (state == STOP1 && !stop2_q));

   // next-state and bit index sequencing
   always_comb begin
      state_n = state;
      bit_idx_n = bit_idx;
      case (state)
         IDLE: begin
            bit_idx_n = 3'd0;
            state_n = accept ? START : IDLE;
         end
         START: state_n = bit_end ? DATA : START;
         DATA: if (bit_end) begin
            bit_idx_n = bit_idx + 3'd1;
            if (bit_idx == {1'b1, nbits_q}) state_n = par_en_q ? PARITY : STOP1;
         end
         PARITY: state_n = bit_end ? STOP1 : PARITY;
         STOP1: state_n = bit_end ? (stop2_q ? STOP2 : IDLE) : STOP1;
         STOP2: state_n = bit_end ? IDLE : STOP2;
         default: state_n = IDLE;
      endcase
   end

   // line level for the state being entered, so sout can be registered
   always_comb begin
      line_n = 1'b1;
      case (state_n)
         START: line_n = 1'b0;
         DATA: line_n = data_q[bit_idx_n];
         PARITY: line_n = ^data_q ^ ~even_q;
         default: line_n = 1'b1;
      endcase
   end

   // state, bit timing counters and registered serial output
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         bit_idx <= 3'd0;
         pre_cnt <= '0;
         tick_cnt <= 4'd0;
         sout <= 1'b1;
      end else begin
         state <= state_n;
         bit_idx <= bit_idx_n;
         sout <= brk ? 1'b0 : line_n;
         if (bit_end || state == IDLE) begin
            pre_cnt <= '0;
            tick_cnt <= 4'd0;
         end else if (tick) begin
            pre_cnt <= '0;
            tick_cnt <= tick_cnt + 4'd1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   // capture the character and its framing at accept; unused high bits are masked off so parity covers only sent bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         data_q <= 8'd0;
         nbits_q <= 2'd0;
         stop2_q <= 1'b0;
         par_en_q <= 1'b0;
         even_q <= 1'b0;
      end else if (accept) begin
         div_q <= divisor;
         data_q <= tx_data & (8'hFF >> (2'd3 - data_bits));
         nbits_q <= data_bits;
         stop2_q <= stop_bits;
         par_en_q <= parity_en;
         even_q <= even_parity;
      end
   end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: scoreboard bench; stimulus queues hand-written line patterns, a monitor decodes sout against them
module tb_uart_tx_engine;
   logic test_clk = 1'b0, reset = 1'b1;
   logic [15:0] divisor = 16'd0;
   logic [1:0] data_bits = 2'd3;
   logic stop_bits = 1'b0, parity_en = 1'b0, even_parity = 1'b0, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'd0;
   logic tx_ready, sout, tx_busy, tx_done;
`ifdef UART_TX_BREAK_EN
   logic brk = 1'b0;
`endif
   int total = 0, bad = 0;
   bit mask_line = 1'b0, mon_active = 1'b0;

   typedef struct {
      string lv;
      int    len;
      int    last_len;
      int    gap;
   } frame_t;
   frame_t exp_q[$];

   always #5 test_clk = ~test_clk;

   uart_tx_engine #(.DIV_W(16)) dut (
      .clk(test_clk),
      .reset(reset),
      .divisor(divisor),
      .data_bits(data_bits),
      .stop_bits(stop_bits),
      .parity_en(parity_en),
      .even_parity(even_parity),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
`ifdef UART_TX_BREAK_EN
      .break_ctrl(brk),
`endif
      .tx_ready(tx_ready),
      .sout(sout),
      .tx_busy(tx_busy),
      .tx_done(tx_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic set_cfg(input logic [15:0] d, input logic [1:0] db, input logic sb, input logic pe, input logic ep);
      divisor = d;
      data_bits = db;
      stop_bits = sb;
      parity_en = pe;
      even_parity = ep;
   endtask

   task automatic push(input string lv, input int len, input int last_len, input int gap);
      frame_t f;
      f.lv = lv;
      f.len = len;
      f.last_len = last_len;
      f.gap = gap;
      exp_q.push_back(f);
   endtask

   task automatic send(input logic [7:0] b, input bit hold);
      int n = 0;
      tx_data = b;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 5000) begin
         @(negedge test_clk);
         n++;
      end
      check("accept_in_time", n < 5000, 1);
      @(posedge test_clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || mon_active || tx_busy) && n < 20000) begin
         @(negedge test_clk);
         n++;
      end
      check("drain_in_time", n < 20000, 1);
      repeat (3) @(negedge test_clk);
   endtask

   // monitor: pops an expected frame on each start bit and checks every bit, tx_done timing and tx_ready after done
   initial begin : monitor
      frame_t e;
      int bi, cyc, blen;
      int idle_cnt;
      bit seen_bad, chk_ready;
      logic want, got_bad;
      bi = 0; cyc = 0; blen = 0; idle_cnt = 1000;
      seen_bad = 0; chk_ready = 0; want = 1'b1; got_bad = 1'b1;
      forever begin
         @(negedge test_clk);
         if (reset) begin
            mon_active = 1'b0;
            chk_ready = 1'b0;
            idle_cnt = 1000;
         end else begin
            if (chk_ready) begin
               check("ready_after_done", tx_ready, 1);
               chk_ready = 1'b0;
            end
            if (!mon_active) begin
               if (sout === 1'b0 && !mask_line) begin
                  if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
                  else begin
                     e = exp_q.pop_front();
                     mon_active = 1'b1;
                     bi = 0;
                     cyc = 0;
                     seen_bad = 1'b0;
                     if (e.gap >= 0) check("idle_gap", idle_cnt, e.gap);
                  end
               end else begin
                  if (tx_done !== 1'b0) check("stray_done", tx_done, 0);
                  idle_cnt++;
               end
            end
            if (mon_active) begin
               blen = (bi == e.lv.len() - 1) ? e.last_len : e.len;
               want = (e.lv.getc(bi) == "1");
               if (!mask_line && sout !== want && !seen_bad) begin
                  seen_bad = 1'b1;
                  got_bad = sout;
               end
               if (bi == e.lv.len() - 1 && cyc == blen - 1) check($sformatf("done_at_end_%s", e.lv), tx_done, 1);
               else if (tx_done !== 1'b0) check($sformatf("early_done_%s_bit%0d", e.lv, bi), tx_done, 0);
               cyc++;
               if (cyc == blen) begin
                  check($sformatf("line_%s_bit%0d", e.lv, bi), seen_bad ? got_bad : want, want);
                  bi++;
                  cyc = 0;
                  seen_bad = 1'b0;
                  if (bi == e.lv.len()) begin
                     mon_active = 1'b0;
                     idle_cnt = 0;
                     chk_ready = 1'b1;
                  end
               end
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge test_clk);
      check("rst_sout", sout, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      reset = 1'b0;
      @(negedge test_clk);
      // 8N1, L=16
      set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
      push("0101001011", 16, 16, -1);
      send(8'hA5, 1'b0);
      wait_idle();
      // 7E2 and 7O2, L=64, bit 7 of 0x83 dropped
      set_cfg(16'd3, 2'd2, 1'b1, 1'b1, 1'b1);
      push("01100000011", 64, 64, -1);
      send(8'h83, 1'b0);
      wait_idle();
      set_cfg(16'd3, 2'd2, 1'b1, 1'b1, 1'b0);
      push("01100000111", 64, 64, -1);
      send(8'h83, 1'b0);
      wait_idle();
      // 5 data bits with 1.5 stop bits: 16 + 8 stop cycles
      set_cfg(16'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      push("01111111", 16, 8, -1);
      send(8'h1F, 1'b0);
      wait_idle();
      // back-to-back with tx_valid held; divisor change mid-character only affects the next one
      set_cfg(16'd1, 2'd3, 1'b0, 1'b0, 1'b0);
      push("0101010101", 32, 32, -1);
      push("0010101011", 16, 16, 1);
      send(8'h55, 1'b1);
      tx_data = 8'hAA;
      repeat (50) @(negedge test_clk);
      divisor = 16'd0;
      send(8'hAA, 1'b0);
      wait_idle();
      // reset during data bit 3
      push("0001111001", 16, 16, -1);
      send(8'h3C, 1'b0);
      repeat (70) @(posedge test_clk);
      #2 reset = 1'b1;
      #1;
      check("abort_sout", sout, 1);
      check("abort_ready", tx_ready, 1);
      check("abort_busy", tx_busy, 0);
      check("abort_done", tx_done, 0);
      @(negedge test_clk);
      @(negedge test_clk);
      reset = 1'b0;
      push("0011010011", 16, 16, -1);
      send(8'h96, 1'b0);
      wait_idle();
      // maximum divisor: start bit must still be held after 5000 cycles, then abort
      set_cfg(16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b0);
      push("0101001011", 1 << 20, 1 << 20, -1);
      send(8'hA5, 1'b0);
      repeat (5000) @(negedge test_clk);
      check("maxdiv_start_held", sout, 0);
      check("maxdiv_busy", tx_busy, 1);
      reset = 1'b1;
      @(negedge test_clk);
      @(negedge test_clk);
      reset = 1'b0;
      set_cfg(16'd0, 2'd3, 1'b0, 1'b0, 1'b0);
      @(negedge test_clk);
      check("maxdiv_after_reset_queue", exp_q.size(), 0);
`ifdef UART_TX_BREAK_EN
      // break mid-character: line forced low, character still completes internally
      push("0000011111", 16, 16, -1);
      send(8'hF0, 1'b0);
      repeat (40) @(negedge test_clk);
      mask_line = 1'b1;
      brk = 1'b1;
      @(negedge test_clk);
      repeat (50) begin
         check("brk_sout", sout, 0);
         check("brk_ready", tx_ready, 0);
         @(negedge test_clk);
      end
      brk = 1'b0;
      @(negedge test_clk);
      mask_line = 1'b0;
      wait_idle();
      check("brk_idle_line", sout, 1);
      push("0111100001", 16, 16, -1);
      send(8'h0F, 1'b0);
      wait_idle();
`endif
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
